// File: rtl/i2c_slave_rx.sv
// Receive-only I2C slave: synchronizes SCL/SDA, detects START/STOP, shifts in
// bytes MSB first, and drives the ACK bit from the consumer's ack_in decision.
module i2c_slave_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_out,
  output logic [7:0] byte_out,
  output logic       valid_out,
  output logic       start_out,
  output logic       stop_out,
  input  logic       ack_in
);

  typedef enum logic [1:0] {IDLE, RX, ACK, ACK_HOLD} state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_hist_q, scl_hist_d;
  logic                   sda_hist_q, sda_hist_d;
  state_e                 state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             byte_q, byte_d;
  logic                   valid_q, valid_d;
  logic                   start_q, start_d;
  logic                   stop_q, stop_d;
  logic                   sda_out_q, sda_out_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall, start_det, stop_det;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  // While we pull SDA low ourselves, its edges are not bus conditions.
  assign start_det = sda_out_q & scl_s & sda_hist_q & ~sda_s;
  assign stop_det  = sda_out_q & scl_s & ~sda_hist_q & sda_s;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_hist_d = scl_s;
    sda_hist_d = sda_s;
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    start_d    = 1'b0;
    stop_d     = 1'b0;
    sda_out_d  = sda_out_q;

    if (start_det) begin
      start_d   = 1'b1;
      bit_cnt_d = 3'd0;
      shift_d   = 8'h00;
      state_d   = RX;
      sda_out_d = 1'b1;
    end else if (stop_det) begin
      stop_d    = 1'b1;
      bit_cnt_d = 3'd0;
      state_d   = IDLE;
      sda_out_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          sda_out_d = 1'b1;
        end
        RX: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_s};
            if (bit_cnt_q == 3'd7) begin
              byte_d    = {shift_q[6:0], sda_s};
              valid_d   = 1'b1;
              bit_cnt_d = 3'd0;
              state_d   = ACK;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        ACK: begin
          if (scl_fall) begin
            if (ack_in) begin
              sda_out_d = 1'b0;
              state_d   = ACK_HOLD;
            end else begin
              state_d = IDLE;
            end
          end
        end
        ACK_HOLD: begin
          if (scl_fall) begin
            sda_out_d = 1'b1;
            state_d   = RX;
          end
        end
        default: begin
          state_d   = IDLE;
          sda_out_d = 1'b1;
        end
      endcase
    end
  end

  // Synchronizers reset to 1 so a released bus looks idle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_out_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      scl_hist_q <= scl_hist_d;
      sda_hist_q <= sda_hist_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_out_q  <= sda_out_d;
    end
  end

  assign sda_out   = sda_out_q;
  assign byte_out  = byte_q;
  assign valid_out = valid_q;
  assign start_out = start_q;
  assign stop_out  = stop_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench for i2c_slave_rx: two instances (SYNC_STAGES 2 and 3) share a wired-AND
// bus driven by a bit-level master; a transaction-level model predicts results.
module tb_i2c_slave_rx;

  localparam int H    = 10;  // SCL half period in clk cycles
  localparam int LAT2 = 3;   // SYNC_STAGES + 1
  localparam int LAT3 = 4;

  logic clk = 1'b0;
  logic rst, scl_m, sda_m, ack_in;
  logic sda_bus;
  logic       sda_out2, valid2, start2, stop2;
  logic       sda_out3, valid3, start3, stop3;
  logic [7:0] byte2, byte3;

  assign sda_bus = sda_m & sda_out2 & sda_out3;

  always #5 clk = ~clk;

  i2c_slave_rx #(.SYNC_STAGES(2)) u_dut2 (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_out(sda_out2),
    .byte_out(byte2), .valid_out(valid2), .start_out(start2), .stop_out(stop2),
    .ack_in(ack_in));

  i2c_slave_rx #(.SYNC_STAGES(3)) u_dut3 (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_bus), .sda_out(sda_out3),
    .byte_out(byte3), .valid_out(valid3), .start_out(start3), .stop_out(stop3),
    .ack_in(ack_in));

  int checks = 0;
  int errors = 0;

  // Observed events
  logic [7:0] got2[$];
  logic [7:0] got3[$];
  int n_start2 = 0, n_start3 = 0, n_stop2 = 0, n_stop3 = 0, wide = 0;
  logic pv2 = 0, ps2 = 0, pp2 = 0, pv3 = 0, ps3 = 0, pp3 = 0;

  // Reference model state
  logic [7:0] exp_q[$];
  logic [7:0] last_exp = 8'h00;
  int  exp_start = 0, exp_stop = 0;
  bit  active = 0;

  // Latency measurement relative to the most recent bus change
  int cyc = 0;
  int lat_s2, lat_s3, lat_v2, lat_v3, lat_p2, lat_p3;

  always @(negedge clk) begin
    if (valid2) got2.push_back(byte2);
    if (valid3) got3.push_back(byte3);
    if (start2) n_start2++;
    if (start3) n_start3++;
    if (stop2)  n_stop2++;
    if (stop3)  n_stop3++;
    if ((valid2 && pv2) || (start2 && ps2) || (stop2 && pp2) ||
        (valid3 && pv3) || (start3 && ps3) || (stop3 && pp3)) wide++;
    pv2 = valid2; ps2 = start2; pp2 = stop2;
    pv3 = valid3; ps3 = start3; pp3 = stop3;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (start2 && lat_s2 == 0) lat_s2 = cyc;
      if (start3 && lat_s3 == 0) lat_s3 = cyc;
      if (valid2 && lat_v2 == 0) lat_v2 = cyc;
      if (valid3 && lat_v3 == 0) lat_v3 = cyc;
      if (stop2  && lat_p2 == 0) lat_p2 = cyc;
      if (stop3  && lat_p3 == 0) lat_p3 = cyc;
    end
  endtask

  task automatic set_bus(input logic s, input logic d);
    @(negedge clk);
    scl_m = s;
    sda_m = d;
    cyc = 0;
    lat_s2 = 0; lat_s3 = 0; lat_v2 = 0; lat_v3 = 0; lat_p2 = 0; lat_p3 = 0;
  endtask

  task automatic i2c_start();
    if (!(scl_m && sda_m)) begin
      set_bus(1'b0, sda_m); wait_cyc(H/2);
      set_bus(1'b0, 1'b1);  wait_cyc(H/2);
      set_bus(1'b1, 1'b1);  wait_cyc(H);
    end
    set_bus(1'b1, 1'b0); wait_cyc(H);
    check("start_lat_s2", lat_s2, LAT2);
    check("start_lat_s3", lat_s3, LAT3);
    exp_start++;
    active = 1;
    set_bus(1'b0, 1'b0); wait_cyc(H);
  endtask

  task automatic i2c_stop();
    if (scl_m) begin
      set_bus(1'b0, sda_m); wait_cyc(H/2);
    end
    set_bus(1'b0, 1'b0); wait_cyc(H/2);
    set_bus(1'b1, 1'b0); wait_cyc(H);
    set_bus(1'b1, 1'b1); wait_cyc(H);
    check("stop_lat_s2", lat_p2, LAT2);
    check("stop_lat_s3", lat_p3, LAT3);
    exp_stop++;
    active = 0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      set_bus(1'b0, sda_m);  wait_cyc(H/2);
      set_bus(1'b0, b[7-i]); wait_cyc(H/2);
      set_bus(1'b1, b[7-i]); wait_cyc(H);
    end
  endtask

  // One byte plus the ninth (ACK) clock; SCL ends low with SDA released.
  task automatic send_byte(input logic [7:0] b, input logic ack);
    bit took;
    bit exp_low;
    int low2, low3;
    took = active;
    ack_in = ack;
    send_bits(b, 8);
    if (took) begin
      check("valid_lat_s2", lat_v2, LAT2);
      check("valid_lat_s3", lat_v3, LAT3);
      exp_q.push_back(b);
      last_exp = b;
    end
    exp_low = took && ack;
    set_bus(1'b0, sda_m); wait_cyc(H/2);
    set_bus(1'b0, 1'b1);  wait_cyc(H/2);
    set_bus(1'b1, 1'b1);
    low2 = 0;
    low3 = 0;
    for (int i = 0; i < H; i++) begin
      wait_cyc(1);
      if (sda_out2 === 1'b0) low2++;
      if (sda_out3 === 1'b0) low3++;
    end
    check("ack_low_cycles_s2", low2, exp_low ? H : 0);
    check("ack_low_cycles_s3", low3, exp_low ? H : 0);
    set_bus(1'b0, 1'b1); wait_cyc(H);
    check("ack_release_s2", sda_out2, 1'b1);
    check("ack_release_s3", sda_out3, 1'b1);
    if (took && !ack) active = 0;
  endtask

  task automatic compare_bytes(input string tag);
    check({tag, "_count_s2"}, got2.size(), exp_q.size());
    check({tag, "_count_s3"}, got3.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got2.size()) check({tag, "_byte_s2"}, got2[i], exp_q[i]);
      if (i < got3.size()) check({tag, "_byte_s3"}, got3[i], exp_q[i]);
    end
    check({tag, "_hold_s2"}, byte2, last_exp);
    check({tag, "_hold_s3"}, byte3, last_exp);
    got2.delete();
    got3.delete();
    exp_q.delete();
  endtask

  initial begin
    int r;
    rst = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    ack_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sda_s2", sda_out2, 1'b1);
    check("rst_sda_s3", sda_out3, 1'b1);
    check("rst_byte_s2", byte2, 8'h00);
    check("rst_byte_s3", byte3, 8'h00);
    check("rst_pulses_s2", {valid2, start2, stop2}, 3'b000);
    check("rst_pulses_s3", {valid3, start3, stop3}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    wait_cyc(H);

    // Single ACKed byte
    i2c_start();
    send_byte(8'hA5, 1'b1);
    compare_bytes("a5");
    i2c_stop();

    // NACKed byte, following byte ignored
    i2c_start();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b1);
    compare_bytes("nack");
    i2c_stop();

    // Two bytes then STOP; a byte after STOP is ignored
    i2c_start();
    send_byte(8'h80, 1'b1);
    send_byte(8'h01, 1'b1);
    i2c_stop();
    send_byte(8'h77, 1'b1);
    compare_bytes("two");

    // Partial byte aborted by repeated START
    i2c_start();
    send_bits(8'hA0, 3);
    i2c_start();
    send_byte(8'h5A, 1'b1);
    compare_bytes("rstart");
    i2c_stop();

    // Reset while holding the ACK low
    i2c_start();
    ack_in = 1'b1;
    send_bits(8'hC3, 8);
    exp_q.push_back(8'hC3);
    set_bus(1'b0, sda_m); wait_cyc(H/2);
    set_bus(1'b0, 1'b1);  wait_cyc(H/2);
    set_bus(1'b1, 1'b1);  wait_cyc(H/2);
    check("hold_low_s2", sda_out2, 1'b0);
    check("hold_low_s3", sda_out3, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_sda_s2", sda_out2, 1'b1);
    check("midrst_sda_s3", sda_out3, 1'b1);
    check("midrst_pulses_s2", {valid2, start2, stop2}, 3'b000);
    check("midrst_pulses_s3", {valid3, start3, stop3}, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    active = 0;
    last_exp = 8'h00;
    wait_cyc(H/2);
    set_bus(1'b0, 1'b1); wait_cyc(H);
    send_byte(8'h11, 1'b1);
    compare_bytes("rst");

    // Randomized transaction mix
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 3);
      case (r)
        0:       i2c_start();
        3:       i2c_stop();
        default: send_byte(8'($urandom), 1'($urandom_range(0, 3) != 0));
      endcase
    end
    i2c_stop();
    compare_bytes("rand");

    check("start_count_s2", n_start2, exp_start);
    check("start_count_s3", n_start3, exp_start);
    check("stop_count_s2", n_stop2, exp_stop);
    check("stop_count_s3", n_stop3, exp_stop);
    check("pulse_width", wide, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
